dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's data-memory port: accepts one load/store request at a time over a req/ack handshake.
//  Inserts WAIT_CYCLES of latency, performs MIPS byte/half/word lane selection and sign/zero extension, and flags misaligned accesses.
//  Sits between the MEM stage (initiator) and a 4 KB word-organised data store; lets the core be tested against a slow memory.
// PARAMETERS
//  ADDR_W       12    byte-address width (4 KB space)
//  DEPTH_WORDS  1024  32-bit words of storage (2**(ADDR_W-2))
//  WAIT_CYCLES  2     extra cycles between accept and ack (0..15)
// PORTS
//  clk     in   1       clock, rising edge
//  rst     in   1       reset, asynchronous, active-low
//  req     in   1       request valid; held by initiator until ack
//  op      in   6       MIPS opcode: LB 20h, LH 21h, LW 23h, LBU 24h, LHU 25h, SB 28h, SH 29h, SW 2Bh
//  addr    in   ADDR_W  byte address
//  wdata   in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  ack     out  1       one-cycle pulse: request completed
//  rdata   out  32      load result, valid while ack=1, extended per op
//  err     out  1       with ack: misaligned or unknown op; no access performed
//  busy    out  1       request accepted and not yet acked
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0; storage array NOT cleared.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req=1 latches op/addr/wdata, busy=1; next state WAIT if WAIT_CYCLES>0 else RESP.
//   WAIT: counter counts 1..WAIT_CYCLES; at terminal count -> RESP.
//   RESP: ack=1 for exactly this cycle; rdata/err valid; store committed at the clock edge leaving RESP; -> IDLE, busy=0.
//  Latency accept->ack = WAIT_CYCLES+1 cycles; back-to-back: next req accepted in the IDLE cycle after ack (req sampled only in IDLE).
//  Inputs changing after accept are ignored (latched copy used).
//  Loads: word index = addr[ADDR_W-1:2]; lane = addr[1:0] (little-endian: byte 0 = bits [7:0]).
//   LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
//  Stores: SB writes one byte lane, SH one half lane, SW full word; other lanes preserved.
//  Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Violation or unlisted op -> err=1 with ack, rdata=0, no write.
//  rdata holds last value outside ack; err is 0 whenever ack=0.
//  Reset asserted mid-transaction: transaction aborted, no ack, no write.
// CONFIGURATION
//  DMEM_ALIGN_TRAP_EN defined: alignment/op checking as above.
//  Not defined: err tied 0; low address bits forced (addr[0]=0 for half, addr[1:0]=0 for word) and access performed;
//   unknown ops behave as LW / no write.
// STRUCTURE
//  Package dmem_pkg: opcode constants OP_LB..OP_SW, FSM state encoding (IDLE/WAIT/RESP), helper is_store(op).
//  Sub-module dmem_lane_align: combinational lane select + extend for loads and byte-enable/write-merge for stores.
//  Top holds FSM, wait counter, request latches, storage array.
// TESTING
//  1 SW addr 010h data DEADBEEF, then LW 010h -> ack exactly WAIT_CYCLES+1 cycles after accept each; rdata=DEADBEEF, err=0.
//  2 SB addr 013h data 80h over DEADBEEF; LB 013h -> FFFFFF80; LBU 013h -> 00000080; LW 010h -> 80ADBEEF.
//  3 SH addr 012h data 8001h; LH 012h -> FFFF8001; LHU 012h -> 00008001; LW 010h -> 8001BEEF.
//  4 TRAP_EN: LW addr 011h -> ack with err=1, rdata=0; following LW 010h unchanged; no-trap build: LW 011h returns word at 010h, err=0.
//  5 WAIT_CYCLES=0 and =3: back-to-back SW/LW with req held high -> ack at accept+1 / accept+4, one ack per request, busy pattern matches.
//  6 Assert rst during WAIT of SW 020h 12345678 -> ack never pulses, busy=0 immediately; LW 020h after reset returns prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MIPS load/store opcodes,
// the responder FSM state encoding and a small store-decode helper.
package dmem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for the data-memory responder: picks the
// addressed byte/half out of a stored word and extends it for loads, and
// merges store data into the stored word for stores.
// Build option DMEM_ALIGN_TRAP_EN: when defined, misaligned accesses and
// unknown opcodes raise err and suppress the access; when undefined the low
// address bits are forced to alignment and unknown opcodes act as LW.
module dmem_lane_align (
  input  logic [5:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] wr_word,
  output logic        wr_en,
  output logic        err
);
  import dmem_pkg::*;

  logic [1:0]  eff_lane;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [3:0]  be;
  logic [31:0] wrep;

  // Legality check (trap build) or address-bit forcing (permissive build)
  always_comb begin
    eff_lane = lane;
    err      = 1'b0;
`ifdef DMEM_ALIGN_TRAP_EN
    case (op)
      OP_LB, OP_LBU, OP_SB: err = 1'b0;
      OP_LH, OP_LHU, OP_SH: err = lane[0];
      OP_LW, OP_SW:         err = |lane;
      default:              err = 1'b1;
    endcase
`else
    case (op)
      OP_LB, OP_LBU, OP_SB: eff_lane = lane;
      OP_LH, OP_LHU, OP_SH: eff_lane = {lane[1], 1'b0};
      default:              eff_lane = 2'b00;
    endcase
`endif
  end

  // Little-endian lane select out of the stored word
  always_comb begin
    sel_byte = rword[7:0];
    case (eff_lane)
      2'd0:    sel_byte = rword[7:0];
      2'd1:    sel_byte = rword[15:8];
      2'd2:    sel_byte = rword[23:16];
      default: sel_byte = rword[31:24];
    endcase
    sel_half = eff_lane[1] ? rword[31:16] : rword[15:0];
  end

  // Load result with sign/zero extension; illegal accesses return zero
  always_comb begin
    load_data = 32'h0;
    if (!err) begin
      case (op)
        OP_LB:               load_data = {{24{sel_byte[7]}}, sel_byte};
        OP_LBU:              load_data = {24'h0, sel_byte};
        OP_LH:               load_data = {{16{sel_half[15]}}, sel_half};
        OP_LHU:              load_data = {16'h0, sel_half};
        OP_SB, OP_SH, OP_SW: load_data = 32'h0;
        default:             load_data = rword;
      endcase
    end
  end

  // Byte enables and write merge; untouched lanes keep their stored value
  always_comb begin
    be      = 4'b0000;
    wrep    = wdata;
    wr_word = rword;
    case (op)
      OP_SB: begin
        be   = 4'b0001 << eff_lane;
        wrep = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be   = eff_lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      OP_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wr_en = is_store(op) && !err;
    if (!wr_en) be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rword[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the pipeline data-memory port. Accepts one
// load/store at a time over req/ack, adds WAIT_CYCLES of latency, and answers
// from a word-organised store with MIPS byte/half/word lane handling.
// Build option DMEM_ALIGN_TRAP_EN selects trapping of misaligned/unknown
// accesses (see dmem_lane_align).
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy
);
  import dmem_pkg::*;

  localparam int         IDX_W    = ADDR_W - 2;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word;
  logic [31:0]       load_data;
  logic [31:0]       wr_word;
  logic              wr_en;
  logic              align_err;

  assign word_idx = addr_q[ADDR_W-1:2];
  assign rd_word  = mem[word_idx];

  dmem_lane_align u_align (
    .op        (op_q),
    .lane      (addr_q[1:0]),
    .rword     (rd_word),
    .wdata     (wdata_q),
    .load_data (load_data),
    .wr_word   (wr_word),
    .wr_en     (wr_en),
    .err       (align_err)
  );

  // Next-state, request latching and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack     = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LIM) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        ack     = 1'b1;
        rdata_d = load_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data is live during the ack cycle and held afterwards
  always_comb begin
    rdata = ack ? load_data : rdata_q;
    err   = ack & align_err;
  end

  // Control state and latched request; reset aborts any open transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 6'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array is not reset; stores commit on the edge leaving RESP
  always_ff @(posedge clk) begin
    if (ack && wr_en) begin
      mem[word_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, back-to-back
// handshake patterns at several latencies, reset abort, and randomized
// traffic against a byte-addressed reference model.
module tb_dmem_responder;

  localparam logic [5:0] T_LB  = 6'h20;
  localparam logic [5:0] T_LH  = 6'h21;
  localparam logic [5:0] T_LW  = 6'h23;
  localparam logic [5:0] T_LBU = 6'h24;
  localparam logic [5:0] T_LHU = 6'h25;
  localparam logic [5:0] T_SB  = 6'h28;
  localparam logic [5:0] T_SH  = 6'h29;
  localparam logic [5:0] T_SW  = 6'h2B;

`ifdef DMEM_ALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a   [3];
  logic [5:0]  op_a    [3];
  logic [11:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic        ack_a   [3];
  logic [31:0] rdata_a [3];
  logic        err_a   [3];
  logic        busy_a  [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [4096];
  logic [5:0] oplist [10];
  vec_t       vecs   [22];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req(req_a[0]), .op(op_a[0]), .addr(addr_a[0]), .wdata(wdata_a[0]),
    .ack(ack_a[0]), .rdata(rdata_a[0]), .err(err_a[0]), .busy(busy_a[0]));

  dmem_responder #(.ADDR_W(12), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req(req_a[1]), .op(op_a[1]), .addr(addr_a[1]), .wdata(wdata_a[1]),
    .ack(ack_a[1]), .rdata(rdata_a[1]), .err(err_a[1]), .busy(busy_a[1]));

  dmem_responder #(.ADDR_W(12), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .req(req_a[2]), .op(op_a[2]), .addr(addr_a[2]), .wdata(wdata_a[2]),
    .ack(ack_a[2]), .rdata(rdata_a[2]), .err(err_a[2]), .busy(busy_a[2]));

  function automatic int wcOf(input int k);
    case (k)
      1:       return 0;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, access size from the opcode
  task automatic modelAccess(input logic [5:0] o, input logic [11:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output logic is_ld);
    int     size;
    int     base;
    logic   sgn;
    logic   st;
    logic   known;
    longint v;
    size = 4; sgn = 1'b0; st = 1'b0; known = 1'b1;
    case (o)
      T_LB:  begin size = 1; sgn = 1'b1; end
      T_LH:  begin size = 2; sgn = 1'b1; end
      T_LW:  size = 4;
      T_LBU: size = 1;
      T_LHU: size = 2;
      T_SB:  begin size = 1; st = 1'b1; end
      T_SH:  begin size = 2; st = 1'b1; end
      T_SW:  begin size = 4; st = 1'b1; end
      default: known = 1'b0;
    endcase
    base  = int'(a);
    rd    = 32'h0;
    er    = 1'b0;
    is_ld = !st;
    if (TRAP && (!known || (base % size) != 0)) begin
      er    = 1'b1;
      is_ld = 1'b1;
      return;
    end
    base = base - (base % size);
    if (st) begin
      for (int i = 0; i < size; i++) mbytes[base + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mbytes[base + i]) << (8*i));
      if (sgn && v[8*size-1]) v = v - (longint'(1) << (8*size));
      rd = v[31:0];
    end
  endtask

  // Drive one request on instance k, scrambling inputs while it is in flight
  task automatic applyStimulus(input int k, input logic [5:0] o, input logic [11:0] a, input logic [31:0] wd,
                               output int lat, output logic [31:0] rd, output logic er, output logic bad,
                               output logic [31:0] rd_hold, output logic hold_bad);
    int idle_wait;
    idle_wait = 0;
    bad = 1'b0; hold_bad = 1'b0; rd = 32'h0; er = 1'b0; rd_hold = 32'h0; lat = 0;
    while (busy_a[k] && idle_wait < 50) begin
      @(posedge clk); #1;
      idle_wait++;
    end
    req_a[k] = 1'b1; op_a[k] = o; addr_a[k] = a; wdata_a[k] = wd;
    @(posedge clk); #1;
    lat = 1;
    while (!ack_a[k] && lat < 40) begin
      if (!busy_a[k] || err_a[k]) bad = 1'b1;
      op_a[k] = 6'($urandom); addr_a[k] = 12'($urandom); wdata_a[k] = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata_a[k];
    er = err_a[k];
    if (!busy_a[k]) bad = 1'b1;
    req_a[k] = 1'b0; op_a[k] = 6'($urandom); addr_a[k] = 12'($urandom); wdata_a[k] = $urandom;
    @(posedge clk); #1;
    rd_hold = rdata_a[k];
    if (ack_a[k] || err_a[k] || busy_a[k]) hold_bad = 1'b1;
  endtask

  task automatic runVec(input int k, input logic [5:0] o, input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic chk_rd, input logic exp_err, input string name);
    int          lat;
    logic [31:0] rd, rdh;
    logic        er, bad, hbad;
    applyStimulus(k, o, a, wd, lat, rd, er, bad, rdh, hbad);
    checkOutput({name, " latency"}, 32'(lat), 32'(wcOf(k) + 1));
    checkOutput({name, " err"}, 32'(er), 32'(exp_err));
    checkOutput({name, " busy/err while waiting"}, 32'(bad), 32'd0);
    checkOutput({name, " idle after ack"}, 32'(hbad), 32'd0);
    if (chk_rd) begin
      checkOutput({name, " rdata"}, rd, exp_rd);
      checkOutput({name, " rdata hold"}, rdh, exp_rd);
    end
  endtask

  // SW then LW with req held high throughout; check the cycle-level pattern
  task automatic backToBack(input int k, input logic [11:0] a, input logic [31:0] d);
    int          w;
    int          acks;
    int          idle_wait;
    logic [31:0] got;
    logic        pat_bad;
    logic        exp_busy, exp_ack;
    w = wcOf(k); acks = 0; got = 32'h0; pat_bad = 1'b0; idle_wait = 0;
    while (busy_a[k] && idle_wait < 50) begin
      @(posedge clk); #1;
      idle_wait++;
    end
    req_a[k] = 1'b1; op_a[k] = T_SW; addr_a[k] = a; wdata_a[k] = d;
    for (int j = 1; j <= 2*w + 6; j++) begin
      @(posedge clk); #1;
      exp_busy = (j <= 2*w + 4) && ((j % (w + 2)) != 0);
      exp_ack  = (j <= 2*w + 4) && ((j % (w + 2)) == w + 1);
      if (busy_a[k] !== exp_busy || ack_a[k] !== exp_ack) pat_bad = 1'b1;
      if (ack_a[k]) begin
        acks++;
        if (acks == 1) begin
          op_a[k] = T_LW; wdata_a[k] = 32'h0;
        end else begin
          got = rdata_a[k];
          req_a[k] = 1'b0;
        end
      end
    end
    req_a[k] = 1'b0;
    checkOutput($sformatf("b2b w%0d pattern", w), 32'(pat_bad), 32'd0);
    checkOutput($sformatf("b2b w%0d ack count", w), 32'(acks), 32'd2);
    checkOutput($sformatf("b2b w%0d rdata", w), got, d);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd, rdh, exp_rd;
    logic        er, bad, hbad, exp_err, is_ld, saw_ack;

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_a[k] = 1'b0; op_a[k] = 6'h0; addr_a[k] = 12'h0; wdata_a[k] = 32'h0;
    end
    oplist = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW, 6'h22, 6'h3F};
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset ack%0d", k), 32'(ack_a[k]), 32'd0);
      checkOutput($sformatf("reset busy%0d", k), 32'(busy_a[k]), 32'd0);
      checkOutput($sformatf("reset err%0d", k), 32'(err_a[k]), 32'd0);
      checkOutput($sformatf("reset rdata%0d", k), rdata_a[k], 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    vecs[0]  = '{T_SW,  12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{T_LW,  12'h010, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2]  = '{T_SB,  12'h013, 32'h00000080, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{T_LB,  12'h013, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0};
    vecs[4]  = '{T_LBU, 12'h013, 32'h0, 32'h00000080, 1'b1, 1'b0};
    vecs[5]  = '{T_LW,  12'h010, 32'h0, 32'h80ADBEEF, 1'b1, 1'b0};
    vecs[6]  = '{T_SH,  12'h012, 32'h00008001, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{T_LH,  12'h012, 32'h0, 32'hFFFF8001, 1'b1, 1'b0};
    vecs[8]  = '{T_LHU, 12'h012, 32'h0, 32'h00008001, 1'b1, 1'b0};
    vecs[9]  = '{T_LW,  12'h010, 32'h0, 32'h8001BEEF, 1'b1, 1'b0};
    vecs[10] = '{T_LW,  12'h011, 32'h0, TRAP ? 32'h0 : 32'h8001BEEF, 1'b1, TRAP};
    vecs[11] = '{T_LW,  12'h010, 32'h0, 32'h8001BEEF, 1'b1, 1'b0};
    vecs[12] = '{T_LB,  12'h010, 32'h0, 32'hFFFFFFEF, 1'b1, 1'b0};
    vecs[13] = '{T_LBU, 12'h011, 32'h0, 32'h000000BE, 1'b1, 1'b0};
    vecs[14] = '{T_LH,  12'h013, 32'h0, TRAP ? 32'h0 : 32'hFFFF8001, 1'b1, TRAP};
    vecs[15] = '{6'h22, 12'h010, 32'h0, TRAP ? 32'h0 : 32'h8001BEEF, 1'b1, TRAP};
    vecs[16] = '{T_SH,  12'h011, 32'h00001234, 32'h0, TRAP, TRAP};
    vecs[17] = '{T_SW,  12'h012, 32'h55555555, 32'h0, TRAP, TRAP};
    vecs[18] = '{T_LW,  12'h010, 32'h0, TRAP ? 32'h8001BEEF : 32'h55555555, 1'b1, 1'b0};
    vecs[19] = '{T_SB,  12'h012, 32'hFFFFFF7F, 32'h0, 1'b0, 1'b0};
    vecs[20] = '{T_LH,  12'h010, 32'h0, TRAP ? 32'hFFFFBEEF : 32'h00005555, 1'b1, 1'b0};
    vecs[21] = '{T_LHU, 12'h012, 32'h0, TRAP ? 32'h0000807F : 32'h0000557F, 1'b1, 1'b0};
    for (int i = 0; i < 22; i++) begin
      runVec(0, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].chk_rd,
             vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    $display("[TB] back-to-back handshakes");
    backToBack(1, 12'h040, 32'hA5A50F0F);
    backToBack(2, 12'h044, 32'h13572468);
    backToBack(0, 12'h048, 32'hFEDCBA98);

    $display("[TB] reset during WAIT");
    runVec(0, T_SW, 12'h020, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, "rst preload");
    req_a[0] = 1'b1; op_a[0] = T_SW; addr_a[0] = 12'h020; wdata_a[0] = 32'h12345678;
    @(posedge clk); #1;
    checkOutput("rst busy in WAIT", 32'(busy_a[0]), 32'd1);
    #2;
    rst = 1'b0;
    req_a[0] = 1'b0;
    #1;
    checkOutput("rst busy cleared", 32'(busy_a[0]), 32'd0);
    checkOutput("rst ack low", 32'(ack_a[0]), 32'd0);
    @(negedge clk); rst = 1'b1;
    saw_ack = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack_a[0] || busy_a[0]) saw_ack = 1'b1;
    end
    checkOutput("rst no ack after abort", 32'(saw_ack), 32'd0);
    runVec(0, T_LW, 12'h020, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, "rst reload");

    $display("[TB] randomized traffic against model");
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      modelAccess(T_SW, 12'(12'h100 + 4*i), d, exp_rd, exp_err, is_ld);
      runVec(0, T_SW, 12'(12'h100 + 4*i), d, 32'h0, 1'b0, 1'b0, $sformatf("seed%0d", i));
    end
    for (int i = 0; i < 150; i++) begin
      logic [5:0]  o;
      logic [11:0] a;
      logic [31:0] d;
      o = oplist[$urandom_range(0, 9)];
      a = 12'(12'h100 + $urandom_range(0, 63));
      d = $urandom;
      modelAccess(o, a, d, exp_rd, exp_err, is_ld);
      applyStimulus(0, o, a, d, lat, rd, er, bad, rdh, hbad);
      checkOutput($sformatf("rnd%0d latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("rnd%0d err", i), 32'(er), 32'(exp_err));
      checkOutput($sformatf("rnd%0d busy/err while waiting", i), 32'(bad | hbad), 32'd0);
      if (is_ld) begin
        checkOutput($sformatf("rnd%0d op %h addr %h rdata", i, o, a), rd, exp_rd);
        checkOutput($sformatf("rnd%0d rdata hold", i), rdh, exp_rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
